mem_access_ctrl: RTL
====================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 32, data-bus width; legal values 32 and 64.
REQ-002 SHALL provide parameter ADDR_WIDTH, default 32, byte-address width.
REQ-003 SHALL provide parameter TIMEOUT, default 255, maximum wait cycles for bus_ready; legal range 1..1023.
REQ-004 SHALL have the following ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  pipeline flush; the result of the in-flight request is dropped.
- req_valid  in  1  pipeline presents a memory operation.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = double (legal only when DATA_WIDTH = 64).
- req_signed  in  1  load result is sign-extended; 0 = zero-extended.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data, right-justified.
- stall  out  1  pipeline must hold the request.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DATA_WIDTH  extended load data; valid with resp_valid.
- exc_misalign  out  1  misaligned or illegal size; valid with resp_valid.
- exc_bus  out  1  bus timeout; valid with resp_valid.
- bus_req  out  1  bus transaction request.
- bus_we  out  1  bus write enable.
- bus_addr  out  ADDR_WIDTH  req_addr with the low log2(DATA_WIDTH/8) bits cleared.
- bus_sel  out  DATA_WIDTH/8  byte-lane enables.
- bus_wdata  out  DATA_WIDTH  lane-shifted store data.
- bus_ready  in  1  bus completes the transaction this cycle.
- bus_rdata  in  DATA_WIDTH  read data; valid when bus_ready = 1.

Function
REQ-005 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-006 In IDLE, with req_valid = 1 and flush = 0, SHALL latch the request and check alignment: byte always aligned, half addr[0] = 0, word addr[1:0] = 0, double addr[2:0] = 0.
REQ-007 An aligned request SHALL go to IDLE->BUSY; bus_req = 1 from the next cycle onward.
REQ-008 A misaligned request, or req_size = 3 when DATA_WIDTH = 32, SHALL go to IDLE->RESP with exc_misalign = 1 and SHALL issue no bus transaction.
REQ-009 In BUSY, bus_req, bus_we, bus_addr, bus_sel and bus_wdata SHALL be driven from latched values and held stable until bus_ready = 1.
REQ-010 With offset = addr mod (DATA_WIDTH/8), bus_sel SHALL equal ((1 << 2^size) - 1) << offset.
REQ-011 bus_wdata SHALL equal req_wdata << (8*offset); unselected lanes don't-care.
REQ-012 On bus_ready = 1 in BUSY, SHALL capture bus_rdata, drop bus_req in the next cycle and go to RESP; bus access latency is 1 cycle minimum.
REQ-013 Load result SHALL be (bus_rdata >> 8*offset), truncated to the access size, then sign- or zero-extended to DATA_WIDTH per the latched req_signed.
REQ-014 For stores, resp_rdata SHALL be 0.
REQ-015 A wait counter SHALL clear on BUSY entry and increment each BUSY cycle without bus_ready.
REQ-016 When the counter reaches TIMEOUT, SHALL drop bus_req, go to RESP with exc_bus = 1 and resp_rdata = 0.
REQ-017 bus_ready in the same cycle as the timeout SHALL win: normal completion, exc_bus = 0.
REQ-018 RESP SHALL last exactly one cycle with resp_valid = 1, then return to IDLE.
REQ-019 A new request SHALL NOT be accepted in RESP.
REQ-020 stall = 1 when (IDLE and req_valid and not flush) or BUSY; stall = 0 in RESP.
REQ-021 Flush in IDLE SHALL block acceptance.
REQ-022 Flush in BUSY SHALL NOT abort the bus; the transaction completes or times out, then resp_valid, exc_misalign and exc_bus are suppressed in RESP.
REQ-023 A flush-pending flag SHALL record a flush seen in BUSY and clear on RESP exit.
REQ-024 exc_misalign and exc_bus SHALL be 0 outside RESP and never both 1.
REQ-025 bus_req SHALL be 0 in IDLE and RESP.

Reset
REQ-026 rst_n = 0 SHALL immediately force IDLE.
REQ-027 rst_n = 0 SHALL clear the wait counter and flush-pending flag, and drive stall, resp_valid, exc_misalign, exc_bus, bus_req, bus_we = 0 and bus_sel, bus_addr, bus_wdata, resp_rdata = 0.
REQ-028 Reset asserted mid-BUSY SHALL abandon the transaction with no response pulse after release.

Verification
REQ-029 DATA_WIDTH=32, load byte, addr 0x1003, signed, bus_rdata 0x80FF_FF_FF after 2 wait cycles -> bus_addr 0x1000, bus_sel 4'b1000, resp_rdata 0xFFFF_FF80, resp_valid 1 cycle, stall high for 4 cycles.
REQ-030 DATA_WIDTH=32, store half, addr 0x2002, wdata 0x0000_BEEF -> bus_we 1, bus_sel 4'b1100, bus_wdata[31:16] 0xBEEF.
REQ-031 Load word at 0x3001 -> no bus_req, resp_valid with exc_misalign 1 one cycle after acceptance.
REQ-032 TIMEOUT=4, bus_ready held 0 -> bus_req drops after 4 BUSY cycles, exc_bus 1; repeat with bus_ready on cycle 4 -> normal completion, exc_bus 0.
REQ-033 DATA_WIDTH=64, load double at 0x8, unsigned -> bus_sel 8'hFF, resp_rdata = bus_rdata; req_size 3 at DATA_WIDTH=32 -> exc_misalign.
REQ-034 Flush during BUSY -> bus transaction completes, no resp_valid; rst_n pulsed mid-BUSY -> all outputs 0, FSM idle.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Load/store unit front end: accepts one pipeline memory operation at a time,
// runs it on a simple ready-handshake bus and returns an aligned, extended result.
module mem_access_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    req_valid,
    input  logic                    req_write,
    input  logic [1:0]              req_size,
    input  logic                    req_signed,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    stall,
    output logic                    resp_valid,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    exc_misalign,
    output logic                    exc_bus,
    output logic                    bus_req,
    output logic                    bus_we,
    output logic [ADDR_WIDTH-1:0]   bus_addr,
    output logic [DATA_WIDTH/8-1:0] bus_sel,
    output logic [DATA_WIDTH-1:0]   bus_wdata,
    input  logic                    bus_ready,
    input  logic [DATA_WIDTH-1:0]   bus_rdata
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t state_q, state_d;

    logic                  lat_write;
    logic                  lat_signed;
    logic [3:0]            lat_bytes;
    logic [OFF_W-1:0]      lat_off;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [NB-1:0]         sel_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  mis_q;
    logic                  bexc_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  flush_pend_q;

    logic                  accept;
    logic                  timeout_hit;
    logic [OFF_W-1:0]      req_off;
    logic [3:0]            req_bytes;
    logic                  req_misalign;
    logic [NB-1:0]         req_sel_base;
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] ld_mask;
    logic [DATA_WIDTH-1:0] load_ext;
    logic                  sign_bit;

    assign accept      = (state_q == IDLE) && req_valid && !flush;
    assign timeout_hit = !bus_ready && (cnt_q == CNT_W'(TIMEOUT - 1));
    assign req_off     = req_addr[OFF_W-1:0];
    assign req_bytes   = 4'd1 << req_size;

    // Double accesses only exist on a 64-bit bus; on 32 bits they are treated as misaligned.
    always_comb begin
        req_misalign = 1'b0;
        case (req_size)
            2'd0:    req_misalign = 1'b0;
            2'd1:    req_misalign = req_addr[0];
            2'd2:    req_misalign = |req_addr[1:0];
            default: req_misalign = (DATA_WIDTH != 64) || (|req_addr[2:0]);
        endcase
    end

    always_comb begin
        req_sel_base = '0;
        for (int i = 0; i < NB; i++) begin
            req_sel_base[i] = (i < int'(req_bytes));
        end
    end

    // Load path: right-justify the addressed lanes, keep the access size, then extend.
    always_comb begin
        shifted  = bus_rdata >> {lat_off, 3'b000};
        ld_mask  = '0;
        sign_bit = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if (i < int'(lat_bytes)) begin
                ld_mask[8*i +: 8] = 8'hFF;
            end
            if (i == int'(lat_bytes) - 1) begin
                sign_bit = shifted[8*i+7];
            end
        end
        load_ext = (shifted & ld_mask) | ((lat_signed && sign_bit) ? ~ld_mask : '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = req_misalign ? RESP : BUSY;
                end
            end
            BUSY: begin
                if (bus_ready || timeout_hit) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latch, wait counter and result capture; bus_ready beats a same-cycle timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_write    <= 1'b0;
            lat_signed   <= 1'b0;
            lat_bytes    <= '0;
            lat_off      <= '0;
            addr_q       <= '0;
            sel_q        <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            mis_q        <= 1'b0;
            bexc_q       <= 1'b0;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        lat_write  <= req_write;
                        lat_signed <= req_signed;
                        lat_bytes  <= req_bytes;
                        lat_off    <= req_off;
                        addr_q     <= {req_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                        sel_q      <= req_sel_base << req_off;
                        wdata_q    <= req_wdata << {req_off, 3'b000};
                        rdata_q    <= '0;
                        mis_q      <= req_misalign;
                        bexc_q     <= 1'b0;
                        cnt_q      <= '0;
                    end
                end
                BUSY: begin
                    if (flush) begin
                        flush_pend_q <= 1'b1;
                    end
                    if (bus_ready) begin
                        rdata_q <= lat_write ? '0 : load_ext;
                    end else if (timeout_hit) begin
                        bexc_q  <= 1'b1;
                        rdata_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    flush_pend_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Bus outputs are only meaningful in BUSY and read as zero otherwise.
    always_comb begin
        bus_req      = (state_q == BUSY);
        bus_we       = bus_req && lat_write;
        bus_addr     = bus_req ? addr_q  : '0;
        bus_sel      = bus_req ? sel_q   : '0;
        bus_wdata    = bus_req ? wdata_q : '0;
        stall        = bus_req || (accept && rst_n);
        resp_valid   = (state_q == RESP) && !flush_pend_q;
        resp_rdata   = resp_valid ? rdata_q : '0;
        exc_misalign = resp_valid && mis_q;
        exc_bus      = resp_valid && bexc_q && !mis_q;
    end

endmodule
